// File: rtl/img2col_ifm_gen.sv
// img2col window gatherer: walks one ksize x ksize (dilated) window over up to CH_MAX channel
// planes, reads the tile buffer and streams words into the matrix buffer. Macro: I2C_ZERO_PAD_EN.
module img2col_ifm_gen #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned KMAX     = 5,
  parameter int unsigned CH_MAX   = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WADDR_W  = 8,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                       clock_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       ready_o,
  output logic                       done_o,
  input  logic [2:0]                 ksize_i,
  input  logic [1:0]                 dilation_i,
  input  logic [3:0]                 channels_i,
  input  logic [5:0]                 tile_length_i,
  input  logic [5:0]                 tile_height_i,
  input  logic signed [6:0]          win_row_i,
  input  logic signed [6:0]          win_col_i,
  input  logic                       hold_i,
  output logic                       ifm_rd_en_o,
  output logic [ADDR_W-1:0]          ifm_rd_addr_o,
  input  logic [SIZE*DATA_WID-1:0]   pixels_in_i,
  output logic                       ifm_wr_en_o,
  output logic [WADDR_W-1:0]         ifm_wr_addr_o,
  output logic [SIZE*DATA_WID-1:0]   pixels_out_o
);

  localparam int unsigned DcW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [DcW-1:0]      dcnt_q, dcnt_d;

  logic [2:0]          ks_q, kw_q, kh_q;
  logic [1:0]          dil_q;
  logic [3:0]          ch_q, c_q;
  logic [5:0]          tl_q, th_q;
  logic signed [6:0]   win_row_q, win_col_q;
  logic signed [31:0]  base_q;
  logic [WADDR_W-1:0]  idx_q;

  logic [RD_LAT-1:0]               vld_q, zro_q;
  logic [RD_LAT-1:0][WADDR_W-1:0]  wa_q;

  logic                issue, last, n_zero, oob, accept;
  logic signed [31:0]  row_s, col_s, tl_s, plane_s;
  logic [ADDR_W-1:0]   tap_addr;

  assign n_zero = (ksize_i == 3'd0) || (32'(ksize_i) > KMAX) ||
                  (channels_i == 4'd0) || (32'(channels_i) > CH_MAX);
  assign accept = (state_q == StIdle) && start_i;
  assign issue  = (state_q == StRun) && !hold_i;
  assign last   = (kw_q == ks_q - 3'd1) && (kh_q == ks_q - 3'd1) && (c_q == ch_q - 4'd1);

  // Signed tap coordinates; the address is formed at full width, then truncated.
  assign row_s    = 32'(win_row_q) + $signed(32'(kh_q) * 32'(dil_q));
  assign col_s    = 32'(win_col_q) + $signed(32'(kw_q) * 32'(dil_q));
  assign tl_s     = $signed(32'(tl_q));
  assign plane_s  = $signed(32'(tl_q) * 32'(th_q));
  assign tap_addr = ADDR_W'(base_q + row_s * tl_s + col_s);

`ifdef I2C_ZERO_PAD_EN
  logic signed [31:0] th_s;
  assign th_s = $signed(32'(th_q));
  assign oob  = (row_s < 0) || (row_s >= th_s) || (col_s < 0) || (col_s >= tl_s);
`else
  assign oob  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (n_zero) done_d = 1'b1;
          else        state_d = StRun;
        end
      end
      StRun: begin
        if (issue && last) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end
      end
      StDrain: begin
        if (dcnt_q == DcW'(RD_LAT - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Window configuration and traversal counters (kw fastest, then kh, then c).
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      ks_q      <= '0;
      dil_q     <= '0;
      ch_q      <= '0;
      tl_q      <= '0;
      th_q      <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      kw_q      <= '0;
      kh_q      <= '0;
      c_q       <= '0;
      base_q    <= '0;
      idx_q     <= '0;
    end else if (accept) begin
      ks_q      <= ksize_i;
      dil_q     <= (dilation_i == 2'd0) ? 2'd1 : dilation_i;
      ch_q      <= channels_i;
      tl_q      <= tile_length_i;
      th_q      <= tile_height_i;
      win_row_q <= win_row_i;
      win_col_q <= win_col_i;
      kw_q      <= '0;
      kh_q      <= '0;
      c_q       <= '0;
      base_q    <= '0;
      idx_q     <= '0;
    end else if (issue) begin
      idx_q <= idx_q + WADDR_W'(1);
      if (kw_q == ks_q - 3'd1) begin
        kw_q <= '0;
        if (kh_q == ks_q - 3'd1) begin
          kh_q   <= '0;
          c_q    <= c_q + 4'd1;
          base_q <= base_q + plane_s;
        end else begin
          kh_q <= kh_q + 3'd1;
        end
      end else begin
        kw_q <= kw_q + 3'd1;
      end
    end
  end

  // Write-side pipeline, RD_LAT deep so its tail lines up with pixels_in_i.
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      zro_q <= '0;
      wa_q  <= '0;
    end else begin
      vld_q[0] <= issue;
      zro_q[0] <= oob;
      wa_q[0]  <= idx_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        zro_q[i] <= zro_q[i-1];
        wa_q[i]  <= wa_q[i-1];
      end
    end
  end

  assign ready_o       = (state_q == StIdle);
  assign done_o        = done_q;
  assign ifm_rd_en_o   = issue && !oob;
  assign ifm_rd_addr_o = ifm_rd_en_o ? tap_addr : '0;
  assign ifm_wr_en_o   = vld_q[RD_LAT-1];
  assign ifm_wr_addr_o = ifm_wr_en_o ? wa_q[RD_LAT-1] : '0;
  assign pixels_out_o  = (ifm_wr_en_o && !zro_q[RD_LAT-1]) ? pixels_in_i : '0;

endmodule

// File: tb/tb_img2col_ifm_gen.sv
// Directed bench for img2col_ifm_gen: tile-buffer model with 2-cycle read latency, event monitor,
// and hand-computed expected read/write/done timing relative to the accepting start edge.
module tb_img2col_ifm_gen;

  logic         clock = 1'b0;
  logic         rst, start, hold;
  logic [2:0]   ksize;
  logic [1:0]   dilation;
  logic [3:0]   channels;
  logic [5:0]   tile_length, tile_height;
  logic [6:0]   win_row, win_col;
  logic         ready, done, rd_en, wr_en;
  logic [9:0]   rd_addr;
  logic [7:0]   wr_addr;
  logic [127:0] pixels_in, pixels_out, rp1, rp2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_rel = -1;
  int done_cnt = 0;
  int rd_rel[$], rd_a[$], wr_rel[$], wr_a[$];
  logic [127:0] wr_d[$];
  int ea1[$], ea2[$], ea3[$];

  img2col_ifm_gen dut (
    .clock_i       (clock),
    .rst_i         (rst),
    .start_i       (start),
    .ready_o       (ready),
    .done_o        (done),
    .ksize_i       (ksize),
    .dilation_i    (dilation),
    .channels_i    (channels),
    .tile_length_i (tile_length),
    .tile_height_i (tile_height),
    .win_row_i     (win_row),
    .win_col_i     (win_col),
    .hold_i        (hold),
    .ifm_rd_en_o   (rd_en),
    .ifm_rd_addr_o (rd_addr),
    .pixels_in_i   (pixels_in),
    .ifm_wr_en_o   (wr_en),
    .ifm_wr_addr_o (wr_addr),
    .pixels_out_o  (pixels_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] mem_word(input int a);
    logic [15:0] lane;
    lane = 16'hA000 ^ 16'(a);
    return {8{lane}};
  endfunction

  // Tile buffer: synchronous read, two-cycle latency.
  always @(posedge clock) begin
    rp1 <= mem_word(int'(rd_addr));
    rp2 <= rp1;
  end
  assign pixels_in = rp2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rd_en) begin
      rd_rel.push_back(cyc - t0 + 1);
      rd_a.push_back(int'(rd_addr));
    end
    if (wr_en) begin
      wr_rel.push_back(cyc - t0 + 1);
      wr_a.push_back(int'(wr_addr));
      wr_d.push_back(pixels_out);
    end else begin
      chk("idle pixels_out", pixels_out, 128'd0);
    end
    if (done) done_cnt++;
  end

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic start_window(input int ks, input int dil, input int ch, input int wr,
                              input int wc);
    ksize       = 3'(ks);
    dilation    = 2'(dil);
    channels    = 4'(ch);
    tile_length = 6'd8;
    tile_height = 6'd8;
    win_row     = 7'(wr);
    win_col     = 7'(wc);
    start       = 1'b1;
    rd_rel.delete(); rd_a.delete(); wr_rel.delete(); wr_a.delete(); wr_d.delete();
    @(posedge clock);
    #1;
    start    = 1'b0;
    t0       = cyc;
    done_rel = -1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic found;
    found = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (done) begin
        found    = 1'b1;
        done_rel = cyc - t0 + 1;
        break;
      end
      adv();
    end
    chk({tag, " done seen"}, found, 1'b1);
  endtask

  // Element i issues at rel 1+i (plus hold_len once i >= hold_at); write 2 cycles later.
  task automatic check_run(input string tag, input int n, input int exp_a[$], input logic [31:0] pad,
                           input int hold_at, input int hold_len);
    int nr, rel;
    nr = 0;
    for (int i = 0; i < n; i++) begin
      rel = 1 + i + ((i >= hold_at) ? hold_len : 0);
      if (!pad[i]) begin
        if (nr < rd_a.size()) begin
          chk($sformatf("%s rd_addr[%0d]", tag, i), rd_a[nr], exp_a[i]);
          chk($sformatf("%s rd_cyc[%0d]", tag, i), rd_rel[nr], rel);
        end
        nr++;
      end
      if (i < wr_a.size()) begin
        chk($sformatf("%s wr_addr[%0d]", tag, i), wr_a[i], i);
        chk($sformatf("%s wr_cyc[%0d]", tag, i), wr_rel[i], rel + 2);
        chk($sformatf("%s wr_data[%0d]", tag, i), wr_d[i], pad[i] ? 128'd0 : mem_word(exp_a[i]));
      end
    end
    chk({tag, " read count"}, rd_a.size(), nr);
    chk({tag, " write count"}, wr_a.size(), n);
    chk({tag, " done cycle"}, done_rel, n + 3 + hold_len);
  endtask

  initial begin
    logic [31:0] pad3;
    ea1 = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    ea2 = '{9, 11, 13, 25, 27, 29, 41, 43, 45, 73, 75, 77, 89, 91, 93, 105, 107, 109};
    ea3 = '{1015, 1016, 1017, 1023, 0, 1, 7, 8, 9};
`ifdef I2C_ZERO_PAD_EN
    pad3 = 32'h4F;
`else
    pad3 = 32'h0;
`endif
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    ksize = '0; dilation = '0; channels = '0;
    tile_length = '0; tile_height = '0; win_row = '0; win_col = '0;
    #2;
    chk("rst ready", ready, 1'b1);
    chk("rst done", done, 1'b0);
    chk("rst rd_en", rd_en, 1'b0);
    chk("rst rd_addr", rd_addr, 10'd0);
    chk("rst wr_en", wr_en, 1'b0);
    chk("rst wr_addr", wr_addr, 8'd0);
    chk("rst pixels_out", pixels_out, 128'd0);
    adv(); adv();
    rst = 1'b0;
    adv();

    // 3x3, dil 1, one channel at the origin.
    start_window(3, 1, 1, 0, 0);
    chk("t1 ready low", ready, 1'b0);
    wait_done("t1", 60);
    check_run("t1", 9, ea1, 32'h0, 99, 0);

    // Back-to-back start in the done cycle: 3x3, dil 2, two channels at (1,1).
    start_window(3, 2, 2, 1, 1);
    chk("t2 ready low", ready, 1'b0);
    wait_done("t2", 80);
    check_run("t2", 18, ea2, 32'h0, 99, 0);
    adv();
    chk("t2 done one pulse", done, 1'b0);
    chk("t2 ready idle", ready, 1'b1);

    // Window hanging off the top-left corner.
    start_window(3, 1, 1, -1, -1);
    wait_done("t3", 60);
    check_run("t3", 9, ea3, pad3, 99, 0);
    adv();

    // Hold for three cycles after element 2 issues.
    start_window(3, 1, 1, 0, 0);
    adv(); adv(); adv();
    hold = 1'b1;
    adv(); adv(); adv();
    hold = 1'b0;
    wait_done("t4", 60);
    check_run("t4", 9, ea1, 32'h0, 3, 3);
    adv();

    // Empty windows: channels=0, then ksize beyond KMAX.
    start_window(3, 1, 0, 0, 0);
    chk("t5 ready", ready, 1'b1);
    wait_done("t5", 10);
    chk("t5 done cycle", done_rel, 1);
    adv();
    chk("t5 done cleared", done, 1'b0);
    chk("t5 reads", rd_a.size(), 0);
    chk("t5 writes", wr_a.size(), 0);
    start_window(6, 1, 1, 0, 0);
    wait_done("t6", 10);
    chk("t6 done cycle", done_rel, 1);
    adv(); adv(); adv();
    chk("t6 reads", rd_a.size(), 0);
    chk("t6 writes", wr_a.size(), 0);

    // A start while busy must not disturb the running window.
    start_window(3, 1, 1, 0, 0);
    adv(); adv();
    ksize = 3'd1; channels = 4'd1; win_row = 7'd2; win_col = 7'd2;
    start = 1'b1;
    adv();
    start = 1'b0;
    wait_done("t7", 60);
    check_run("t7", 9, ea1, 32'h0, 99, 0);
    adv();

    // Asynchronous reset in the middle of a window.
    start_window(3, 1, 1, 0, 0);
    adv(); adv(); adv(); adv();
    rd_rel.delete(); rd_a.delete(); wr_rel.delete(); wr_a.delete(); wr_d.delete();
    done_cnt = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("t8 ready", ready, 1'b1);
    chk("t8 rd_en", rd_en, 1'b0);
    chk("t8 rd_addr", rd_addr, 10'd0);
    chk("t8 wr_en", wr_en, 1'b0);
    chk("t8 wr_addr", wr_addr, 8'd0);
    chk("t8 pixels_out", pixels_out, 128'd0);
    adv(); adv();
    rst = 1'b0;
    repeat (6) adv();
    chk("t8 no writes", wr_a.size(), 0);
    chk("t8 no reads", rd_a.size(), 0);
    chk("t8 no done", done_cnt, 0);
    start_window(3, 1, 1, 0, 0);
    wait_done("t9", 60);
    check_run("t9", 9, ea1, 32'h0, 99, 0);
    adv(); adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
